// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue controller.
//   - data/opcode widths and the opcode encodings of the 64-bit ALU
//   - ALU_LATENCY: clock edges from operand registration to Z being valid
//   - alu_result_t: the ALU result bundle stored in the response FIFO
//   - is_legal_op(): true for opcodes the ALU implements
package alu_issue_pkg;

  localparam int DATA_W      = 64;
  localparam int OP_W        = 4;
  localparam int ALU_LATENCY = 2;

  localparam logic [OP_W-1:0] OP_AND = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
  localparam logic [OP_W-1:0] OP_XOR = 4'b0010;
  localparam logic [OP_W-1:0] OP_SHL = 4'b0100;
  localparam logic [OP_W-1:0] OP_SHR = 4'b0101;
  localparam logic [OP_W-1:0] OP_ADD = 4'b1000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b1001;
  localparam logic [OP_W-1:0] OP_LT  = 4'b1010;
  localparam logic [OP_W-1:0] OP_LTU = 4'b1011;
  localparam logic [OP_W-1:0] OP_GT  = 4'b1100;
  localparam logic [OP_W-1:0] OP_GE  = 4'b1101;
  localparam logic [OP_W-1:0] OP_EQ  = 4'b1110;
  localparam logic [OP_W-1:0] OP_NE  = 4'b1111;

  typedef struct packed {
    logic [DATA_W-1:0] z;
    logic              carry;
    logic              overflow;
  } alu_result_t;

  localparam int RESULT_W = $bits(alu_result_t);

  // 0011, 0110 and 0111 are holes in the ALU's opcode map.
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return !((op == 4'b0011) || (op == 4'b0110) || (op == 4'b0111));
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bus bundle for alu_issue_ctrl: request channel, response channel,
// ALU drive/return signals and the busy flag.
//   master : sequencer side (drives requests, accepts responses)
//   slave  : alu_issue_ctrl
//   alu    : the ALU64bit side (consumes drive, returns Z/flags)
//
// Handshake (both req_* and rsp_*): a transfer happens on the rising clock
// edge of any cycle in which valid and ready are both high. The sender holds
// valid and payload steady until that cycle; ready may change freely and
// never depends on valid of the same channel.
interface alu_issue_ctrl_if
  import alu_issue_pkg::*;
#(
  parameter int TAG_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [OP_W-1:0]   req_op;
  logic [TAG_W-1:0]  req_tag;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_opcode;
  logic [DATA_W-1:0] alu_z;
  logic              alu_carry;
  logic              alu_overflow;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_z;
  logic              rsp_carry;
  logic              rsp_overflow;
  logic              rsp_err;
  logic [TAG_W-1:0]  rsp_tag;

  logic              busy;

  modport master (
    output req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_z, rsp_carry, rsp_overflow,
           rsp_err, rsp_tag, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
           alu_z, alu_carry, alu_overflow,
    output req_ready, rsp_valid, rsp_z, rsp_carry, rsp_overflow,
           rsp_err, rsp_tag, busy, alu_a, alu_b, alu_opcode
  );

  modport alu (
    input  alu_a, alu_b, alu_opcode,
    output alu_z, alu_carry, alu_overflow
  );

endinterface

// File: rtl/alu_rsp_fifo.sv
// Synchronous FIFO with occupancy count; holds completed ALU responses.
//   clk, rst     : clock, synchronous active-high reset (clears pointers/count)
//   push_i       : write push_data_i (ignored when full)
//   pop_i        : advance read pointer (ignored when empty)
//   pop_data_o   : current head entry
//   count_o      : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so pointers wrap naturally.
module alu_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the count decides what is meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Front end for the 2-cycle pipelined 64-bit ALU.
//   clk, rst : clock, synchronous active-high reset (also resets the ALU)
//   bus      : alu_issue_ctrl_if.slave
//     req_*  : operation requests (valid/ready), tag returned with response
//     alu_*  : ALU operand drive and result return
//     rsp_*  : in-order responses from the response FIFO (valid/ready)
//     busy   : any operation in the valid pipe or the FIFO
// One request may be accepted per cycle. A tagged valid pipe tracks each
// operation through the ALU latency; on leaving the pipe the ALU result is
// written into the FIFO. Requests are only accepted while a FIFO slot is
// guaranteed for every operation already in flight (credit scheme).
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input logic             clk,
  input logic             rst,
  alu_issue_ctrl_if.slave bus
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int FIFO_W = RESULT_W + 1 + TAG_W;
  localparam int LAST   = ALU_LATENCY - 1;

  logic                   accept, legal, issue;
  logic [ALU_LATENCY-1:0] pv_q, pv_d;
  logic [TAG_W-1:0]       ptag_q [ALU_LATENCY];
  logic [TAG_W-1:0]       ptag_d [ALU_LATENCY];
  logic                   perr_q [ALU_LATENCY];
  logic                   perr_d [ALU_LATENCY];

  logic                   push, pop;
  alu_result_t            cap_res;
  logic [FIFO_W-1:0]      push_data, head;
  logic [CNT_W-1:0]       fifo_count;
  logic [CNT_W:0]         inflight;

  // ---------------------------------------------------------------- issue
  assign legal  = is_legal_op(bus.req_op);
  assign accept = bus.req_valid && bus.req_ready;
  assign issue  = accept && legal;

  // Illegal or absent requests present zeros so the ALU sees a quiet input.
  assign bus.alu_a      = issue ? bus.req_a  : '0;
  assign bus.alu_b      = issue ? bus.req_b  : '0;
  assign bus.alu_opcode = issue ? bus.req_op : '0;

  // ----------------------------------------------------------- valid pipe
  always_comb begin
    pv_d   = pv_q;
    ptag_d = ptag_q;
    perr_d = perr_q;
    for (int i = LAST; i > 0; i--) begin
      pv_d[i]   = pv_q[i-1];
      ptag_d[i] = ptag_q[i-1];
      perr_d[i] = perr_q[i-1];
    end
    pv_d[0]   = accept;
    ptag_d[0] = bus.req_tag;
    perr_d[0] = !legal;
  end

  always_ff @(posedge clk) begin
    if (rst) pv_q <= '0;
    else     pv_q <= pv_d;
  end

  // Tag/err are only meaningful alongside their valid bit.
  always_ff @(posedge clk) begin
    ptag_q <= ptag_d;
    perr_q <= perr_d;
  end

  // -------------------------------------------------------------- capture
  // The last pipe stage lines up with the cycle in which the ALU's Z
  // register holds this operation's result.
  always_comb begin
    cap_res = '0;
    if (!perr_q[LAST]) begin
      cap_res = '{z: bus.alu_z, carry: bus.alu_carry, overflow: bus.alu_overflow};
    end
    push_data = {cap_res, perr_q[LAST], ptag_q[LAST]};
  end

  assign push = pv_q[LAST];
  assign pop  = bus.rsp_valid && bus.rsp_ready;

  alu_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .pop_data_o  (head),
    .count_o     (fifo_count)
  );

  // --------------------------------------------------------------- credit
  // Every in-flight operation owns a future FIFO slot. A pop in this cycle
  // is deliberately not counted, keeping req_ready off the rsp_ready path.
  always_comb begin
    inflight = {1'b0, fifo_count};
    for (int i = 0; i < ALU_LATENCY; i++) begin
      inflight = inflight + (CNT_W+1)'(pv_q[i]);
    end
  end

  assign bus.req_ready = inflight < (CNT_W+1)'(FIFO_DEPTH);

  // ------------------------------------------------------------- response
  // Payload is gated so an empty FIFO never exposes stale storage.
  assign bus.rsp_valid    = fifo_count != '0;
  assign bus.rsp_z        = bus.rsp_valid ? head[FIFO_W-1 -: DATA_W] : '0;
  assign bus.rsp_carry    = bus.rsp_valid && head[TAG_W+2];
  assign bus.rsp_overflow = bus.rsp_valid && head[TAG_W+1];
  assign bus.rsp_err      = bus.rsp_valid && head[TAG_W];
  assign bus.rsp_tag      = bus.rsp_valid ? head[TAG_W-1:0] : '0;

  assign bus.busy = (|pv_q) || (fifo_count != '0);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 2-stage ALU stand-in.
module tb_alu_issue_ctrl;
  import alu_issue_pkg::*;

  localparam int TAG_W      = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int RSP_W      = DATA_W + 3 + TAG_W;

  // ------------------------------------------------------ clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  alu_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

  alu_issue_ctrl #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .TAG_W      (TAG_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ----------------------------------------------------- ALU stand-in
  // Edge 1 registers operands, edge 2 registers Z/carry/overflow.
  logic [63:0] a_r, b_r;
  logic [3:0]  op_r;

  function automatic logic [65:0] alu_fn(input logic [63:0] a, input logic [63:0] b,
                                         input logic [3:0] op);
    logic [64:0] s;
    logic [63:0] z;
    logic        c, ov;
    s = '0; z = '0; c = 1'b0; ov = 1'b0;
    case (op)
      OP_AND: z = a & b;
      OP_OR:  z = a | b;
      OP_XOR: z = a ^ b;
      OP_SHL: z = a << b[5:0];
      OP_SHR: z = a >> b[5:0];
      OP_ADD: begin
        s  = {1'b0, a} + {1'b0, b};
        z  = s[63:0];
        c  = s[64];
        ov = (a[63] == b[63]) && (z[63] != a[63]);
      end
      OP_SUB: begin
        s  = {1'b0, a} + {1'b0, ~b} + 65'd1;
        z  = s[63:0];
        c  = s[64];
        ov = (a[63] != b[63]) && (z[63] != a[63]);
      end
      OP_LT:  z = {63'd0, $signed(a) < $signed(b)};
      OP_LTU: z = {63'd0, a < b};
      OP_GT:  z = {63'd0, $signed(a) > $signed(b)};
      OP_GE:  z = {63'd0, $signed(a) >= $signed(b)};
      OP_EQ:  z = {63'd0, a == b};
      OP_NE:  z = {63'd0, a != b};
      default: z = '0;
    endcase
    return {c, ov, z};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      a_r <= '0; b_r <= '0; op_r <= '0;
      bus.alu_z <= '0; bus.alu_carry <= 1'b0; bus.alu_overflow <= 1'b0;
    end else begin
      a_r  <= bus.alu_a;
      b_r  <= bus.alu_b;
      op_r <= bus.alu_opcode;
      {bus.alu_carry, bus.alu_overflow, bus.alu_z} <= alu_fn(a_r, b_r, op_r);
    end
  end

  // -------------------------------------------------------------- check
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // --------------------------------------------------------- scoreboard
  logic [RSP_W-1:0] exp_q[$];
  int               pop_cyc [16];
  int               acc_cyc = 0;

  task automatic expect_rsp(input logic [63:0] z, input logic c, input logic ov,
                            input logic err, input logic [3:0] tag);
    exp_q.push_back({z, c, ov, err, tag});
  endtask

  always @(negedge clk) begin
    logic [RSP_W-1:0] got;
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      got = {bus.rsp_z, bus.rsp_carry, bus.rsp_overflow, bus.rsp_err, bus.rsp_tag};
      if (exp_q.size() == 0) check("unexpected_rsp", 128'({1'b1, got}), 128'(0));
      else                   check("rsp", 128'(got), 128'(exp_q.pop_front()));
      pop_cyc[bus.rsp_tag] = cyc;
    end
  end

  // ------------------------------------------------------------ drivers
  // Called at posedge+1; returns at posedge+1 after the accepting edge
  // with req_valid still high so consecutive calls issue back-to-back.
  task automatic issue(input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] op, input logic [3:0] tag);
    int   n;
    logic illegal;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_op    = op;
    bus.req_tag   = tag;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check("issue_timeout", 128'(bus.req_ready), 128'(1));
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      return;
    end
    illegal = (op == 4'b0011) || (op == 4'b0110) || (op == 4'b0111);
    acc_cyc = cyc;
    check("alu_opcode", 128'(bus.alu_opcode), 128'(illegal ? 4'd0 : op));
    check("alu_a", 128'(bus.alu_a), 128'(illegal ? 64'd0 : a));
    check("alu_b", 128'(bus.alu_b), 128'(illegal ? 64'd0 : b));
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.req_tag   = '0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", 128'(exp_q.size()), 128'(0));
    @(posedge clk); #1;
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    int n;
    idle();
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 128'(bus.req_ready), 128'(1));
    check("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_rsp_z", 128'(bus.rsp_z), 128'(0));
    check("rst_rsp_flags", 128'({bus.rsp_carry, bus.rsp_overflow, bus.rsp_err}), 128'(0));
    check("rst_rsp_tag", 128'(bus.rsp_tag), 128'(0));
    check("rst_alu_drive", 128'({bus.alu_opcode, bus.alu_a}), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single ADD, latency 3 from accept to rsp_valid.
    expect_rsp(64'd8, 1'b0, 1'b0, 1'b0, 4'd1);
    issue(64'd5, 64'd3, OP_ADD, 4'd1);
    idle();
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("add_latency", 128'(cyc - acc_cyc), 128'(3));
    wait_drain();

    // Back-to-back SUB / LT, responses on consecutive cycles.
    expect_rsp(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 4'd2);
    expect_rsp(64'd1, 1'b0, 1'b0, 1'b0, 4'd3);
    issue(64'd3, 64'd5, OP_SUB, 4'd2);
    issue(64'd3, 64'd5, OP_LT, 4'd3);
    idle();
    wait_drain();
    check("b2b_spacing", 128'(pop_cyc[3] - pop_cyc[2]), 128'(1));

    // Signed overflow on ADD.
    expect_rsp(64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 4'd6);
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD, 4'd6);
    idle();
    wait_drain();

    // Backpressure: only FIFO_DEPTH accepted while rsp_ready is low.
    expect_rsp(64'h30, 1'b0, 1'b0, 1'b0, 4'd0);
    expect_rsp(64'hFF, 1'b0, 1'b0, 1'b0, 4'd1);
    expect_rsp(64'hF0, 1'b0, 1'b0, 1'b0, 4'd2);
    expect_rsp(64'd7,  1'b1, 1'b0, 1'b0, 4'd3);
    expect_rsp(64'd123, 1'b0, 1'b0, 1'b0, 4'd4);
    expect_rsp(64'd1,  1'b0, 1'b0, 1'b0, 4'd5);
    bus.rsp_ready = 1'b0;
    issue(64'hF0, 64'h3C, OP_AND, 4'd0);
    issue(64'hF0, 64'h0F, OP_OR,  4'd1);
    issue(64'hFF, 64'h0F, OP_XOR, 4'd2);
    issue(64'd10, 64'd3,  OP_SUB, 4'd3);
    bus.req_valid = 1'b1;
    bus.req_a     = 64'd100;
    bus.req_b     = 64'd23;
    bus.req_op    = OP_ADD;
    bus.req_tag   = 4'd4;
    repeat (6) @(negedge clk);
    check("bp_req_ready_low", 128'(bus.req_ready), 128'(0));
    check("bp_rsp_valid", 128'(bus.rsp_valid), 128'(1));
    check("bp_head_tag", 128'(bus.rsp_tag), 128'(0));
    check("bp_busy", 128'(bus.busy), 128'(1));
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_pop_not_credited", 128'(bus.req_ready), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_ready_after_pop", 128'(bus.req_ready), 128'(1));
    @(posedge clk); #1;
    issue(64'd1, 64'd2, OP_NE, 4'd5);
    idle();
    wait_drain();

    // Illegal opcode between two legal ones.
    expect_rsp(64'd2,  1'b0, 1'b0, 1'b0, 4'd4);
    expect_rsp(64'd0,  1'b0, 1'b0, 1'b1, 4'd7);
    expect_rsp(64'h0F, 1'b0, 1'b0, 1'b0, 4'd5);
    issue(64'd1, 64'd1, OP_ADD, 4'd4);
    issue(64'hDEAD, 64'hBEEF, 4'b0011, 4'd7);
    issue(64'hFF, 64'h0F, OP_AND, 4'd5);
    idle();
    wait_drain();

    // Reset with two operations in the pipe and two in the FIFO.
    bus.rsp_ready = 1'b0;
    issue(64'd8,  64'd8,  OP_ADD, 4'd8);
    issue(64'd9,  64'd9,  OP_ADD, 4'd9);
    issue(64'd10, 64'd10, OP_ADD, 4'd10);
    issue(64'd11, 64'd11, OP_ADD, 4'd11);
    idle();
    @(negedge clk);
    check("pre_reset_busy", 128'(bus.busy), 128'(1));
    check("pre_reset_rsp_valid", 128'(bus.rsp_valid), 128'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_rsp_valid", 128'(bus.rsp_valid), 128'(0));
    check("post_reset_busy", 128'(bus.busy), 128'(0));
    check("post_reset_req_ready", 128'(bus.req_ready), 128'(1));
    bus.rsp_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("post_reset_quiet", 128'(bus.rsp_valid), 128'(0));
    @(posedge clk); #1;

    // Recovery after reset.
    expect_rsp(64'd1, 1'b0, 1'b0, 1'b0, 4'd12);
    issue(64'd7, 64'd7, OP_EQ, 4'd12);
    idle();
    wait_drain();

    check("sb_empty", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
